scan_arbiter_ctrl: RTL and testbench
====================================

Name: scan_arbiter_ctrl

Overview:
- Controller and arbiter that shares one bounded-scan engine between two requesters.
- The engine is an index x counting from 0 up to a bound n; m records the last index at which the active requester's selector was high.
- The block grants the engine round-robin, loads the winner's bound, steps the scan, then returns a done pulse with the captured result.
- Sits between the requesters and downstream logic that consumes x/m/n.

Parameters:
- W, 11, width of x, m, n and the bound inputs.
- DEFAULT_BOUND, 500, value of n after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester scan request; level, held until done or until abort.
- bound0  in  W  scan bound of requester 0; sampled only at grant.
- bound1  in  W  scan bound of requester 1; sampled only at grant.
- sel0  in  1  selector of requester 0; used only while requester 0 is granted.
- sel1  in  1  selector of requester 1; used only while requester 1 is granted.
- step  in  1  advance enable for the scan.
- gnt  out  2  one-hot grant, or 0 when idle.
- busy  out  1  high in RUN and DONE.
- x  out  W  current scan index.
- m  out  W  last selected index.
- n  out  W  active bound.
- hit  out  1  at least one selection occurred in the current scan.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester index that owns the current done pulse.

Behaviour:
- Reset (async, rst_n=0), all outputs and state registers:
  - state=IDLE.
  - x=0, m=0, n=DEFAULT_BOUND.
  - gnt=0, busy=0, hit=0, done=0, done_id=0.
  - Round-robin pointer favours requester 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req is nonzero, pick the winner. The requester served last has lower priority; with a single requester, that requester wins.
  - On the same edge: gnt becomes one-hot for the winner; n is loaded from that winner's bound; x=0, m=0, hit=0; state goes to RUN.
  - Latency: a req sampled at edge k gives gnt high from edge k onward.
  - Otherwise x, m and n hold their values.
- RUN (sel_g is the selected requester's sel):
  - If x<n and step=1: x<=x+1. If sel_g=1 on that cycle, also m<=x and hit<=1.
  - If x<n and step=0: all registers hold.
  - If x>=n: go to DONE. x is not incremented and there is no capture that cycle.
  - Bound n=0: x>=n on the first RUN cycle, so the next state is DONE with m=0 and hit=0.
  - Abort: if the granted requester's req bit is 0, go to IDLE on the next edge. gnt clears, there is no done pulse, x/m/n hold, and the round-robin pointer still advances past the aborted requester.
- DONE:
  - done=1 and done_id=granted index for exactly one cycle; gnt is still held.
  - Next edge: go to IDLE, gnt=0, the pointer records the served requester.
  - x, m, n and hit hold until the next grant, so the result stays readable after done.
- Invariants:
  - At most one gnt bit is set.
  - x<=n at all times in RUN/DONE.
  - hit=1 implies m<n.
  - In DONE, x==n.
  - No x increment occurs when x>=n, so there is no wrap-around.
- Arithmetic:
  - Comparisons are unsigned W-bit.
  - x+1 never overflows, because increment requires x<n<=2^W-1.
- Simultaneous events: a new req arriving while busy waits; it is arbitrated in the first IDLE cycle after DONE or abort. IDLE therefore lasts at least one cycle between grants.
- Reset mid-scan: immediate return to reset values; no done pulse.

Decomposition:
- Shared package scan_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - localparam W=11;
  - DEFAULT_BOUND;
  - a typedef for the W-bit index.
- One natural sub-module, rr_arb2: two-requester round-robin arbiter with a last-served pointer. It takes req and an update strobe, and outputs a one-hot grant.
- Scan datapath and FSM stay in scan_arbiter_ctrl.

Test Plan:
- Reset, then req=01, bound0=5, step=1, sel0 high only while x=3 → gnt=01, x steps 0..5, m=3, hit=1, done=1 with done_id=0 one cycle after x reaches 5, gnt=00 on the next cycle.
- req=11 held continuously, bound0=2, bound1=3, step=1 → grants alternate 01,10,01. Each pair of grants is separated by one IDLE cycle. done_id alternates 0,1,0.
- bound1=0, req=10 → RUN then DONE on the next cycle. m=0, hit=0, x=0, one done pulse.
- bound0=4, step toggling 1,0,1,0…, sel0=1 always → x advances only on step cycles; final m=3, x=4, exactly one done.
- Scan with bound0=100, drop req[0] at x=10 → IDLE on the next edge, no done, x=10 held. A pending req[1] is granted next, with the pointer past requester 0.
- Assert rst_n=0 mid-scan at x=7 → x=0, m=0, n=500, gnt=0 immediately (async). Scanning resumes only after rst_n=1 and a new req.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the two-requester bounded-scan controller.
package scan_pkg;

  localparam int unsigned W             = 11;
  localparam int unsigned DEFAULT_BOUND = 500;

  typedef logic [W-1:0] idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/scan_arbiter_ctrl_if.sv
// Requester-side bundle of the scan controller; clock and reset stay outside.
interface scan_arbiter_ctrl_if;
  import scan_pkg::*;

  logic [1:0] req;
  idx_t       bound0;
  idx_t       bound1;
  logic       sel0;
  logic       sel1;
  logic       step;
  logic [1:0] gnt;
  logic       busy;
  idx_t       x;
  idx_t       m;
  idx_t       n;
  logic       hit;
  logic       done;
  logic       done_id;

  modport master (
    output req, bound0, bound1, sel0, sel1, step,
    input  gnt, busy, x, m, n, hit, done, done_id
  );

  modport slave (
    input  req, bound0, bound1, sel0, sel1, step,
    output gnt, busy, x, m, n, hit, done, done_id
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the requester served last loses a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Recording the winner at grant time is equivalent to recording it at release:
  // no arbitration happens while a scan is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/scan_arbiter_ctrl.sv
// Grants one bounded-scan engine to two requesters in turn and reports each scan result.
module scan_arbiter_ctrl
  import scan_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  scan_arbiter_ctrl_if.slave  bus
);

  state_e     state_q;
  logic [1:0] gnt_q;
  logic       busy_q;
  idx_t       x_q;
  idx_t       m_q;
  idx_t       n_q;
  logic       hit_q;
  logic       done_q;
  logic       done_id_q;
  logic       owner_q;

  logic [1:0] arb_gnt;
  logic       arb_upd;
  logic       sel_g;
  logic       req_g;

  assign arb_upd = (state_q == StIdle);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req),
    .upd   (arb_upd),
    .gnt   (arb_gnt)
  );

  assign sel_g = owner_q ? bus.sel1 : bus.sel0;
  assign req_g = owner_q ? bus.req[1] : bus.req[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      x_q       <= '0;
      m_q       <= '0;
      n_q       <= idx_t'(DEFAULT_BOUND);
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arb_gnt != 2'b00) begin
            gnt_q   <= arb_gnt;
            owner_q <= arb_gnt[1];
            n_q     <= arb_gnt[1] ? bus.bound1 : bus.bound0;
            x_q     <= '0;
            m_q     <= '0;
            hit_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Abort wins over completion; the result registers keep their values.
          if (!req_g) begin
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (x_q >= n_q) begin
            done_q    <= 1'b1;
            done_id_q <= owner_q;
            state_q   <= StDone;
          end else if (bus.step) begin
            x_q <= x_q + idx_t'(1);
            if (sel_g) begin
              m_q   <= x_q;
              hit_q <= 1'b1;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.x       = x_q;
  assign bus.m       = m_q;
  assign bus.n       = n_q;
  assign bus.hit     = hit_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_scan_arbiter_ctrl.sv
// Bench for scan_arbiter_ctrl: behavioural model checked every cycle plus directed literal checks.
module tb_scan_arbiter_ctrl;
  import scan_pkg::*;

  logic clk;
  logic rst_n;

  scan_arbiter_ctrl_if bus ();

  scan_arbiter_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the engine, whether the scan has finished, and the scan registers.
  int   m_owner;
  int   m_last;
  bit   m_fin;
  int   m_did;
  int   m_x;
  int   m_m;
  int   m_n;
  bit   m_hit;
  logic m_sel;

  always_comb m_sel = (m_owner == 1) ? bus.sel1 : bus.sel0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 1;
      m_fin   <= 1'b0;
      m_did   <= 0;
      m_x     <= 0;
      m_m     <= 0;
      m_n     <= DEFAULT_BOUND;
      m_hit   <= 1'b0;
    end else if (m_owner < 0) begin
      if (bus.req != 2'b00) begin
        if (bus.req == 2'b11) begin
          m_owner <= 1 - m_last;
          m_last  <= 1 - m_last;
          m_n     <= (m_last == 0) ? int'(bus.bound1) : int'(bus.bound0);
        end else begin
          m_owner <= bus.req[1] ? 1 : 0;
          m_last  <= bus.req[1] ? 1 : 0;
          m_n     <= bus.req[1] ? int'(bus.bound1) : int'(bus.bound0);
        end
        m_x   <= 0;
        m_m   <= 0;
        m_hit <= 1'b0;
      end
    end else if (m_fin) begin
      m_owner <= -1;
      m_fin   <= 1'b0;
    end else if (!bus.req[m_owner]) begin
      m_owner <= -1;
    end else if (m_x >= m_n) begin
      m_fin <= 1'b1;
      m_did <= m_owner;
    end else if (bus.step) begin
      m_x <= m_x + 1;
      if (m_sel) begin
        m_m   <= m_x;
        m_hit <= 1'b1;
      end
    end
  end

  // Observations of the DUT used by the directed literal checks.
  int         n_done = 0;
  bit         did_seen[$];
  logic [1:0] gnt_seen[$];
  int         gaps[$];
  int         idle_run = 0;
  logic [1:0] prev_gnt = 2'b00;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt",  32'(bus.gnt),  (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
      chk("x",    32'(bus.x),    32'(m_x));
      chk("m",    32'(bus.m),    32'(m_m));
      chk("n",    32'(bus.n),    32'(m_n));
      chk("hit",  32'(bus.hit),  32'(m_hit));
      chk("done", 32'(bus.done), 32'(m_fin));
      if (m_fin) chk("done_id", 32'(bus.done_id), 32'(m_did));
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      if (bus.busy) chk("x_le_n", 32'(bus.x <= bus.n), 32'd1);
      if (bus.done) begin
        n_done++;
        did_seen.push_back(bus.done_id);
      end
      if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
        gnt_seen.push_back(bus.gnt);
        gaps.push_back(idle_run);
      end
      idle_run = (bus.gnt == 2'b00) ? idle_run + 1 : 0;
      prev_gnt = bus.gnt;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    n_done = 0;
    did_seen.delete();
    gnt_seen.delete();
    gaps.delete();
  endtask

  // selx: -1 selector always high, -2 never high, otherwise high only while x == selx.
  task automatic run_until_done(input int want, input bit toggle, input int selx);
    int budget;
    budget = 400;
    forever begin
      tick();
      if (n_done >= want) begin
        bus.req = 2'b00;
        break;
      end
      if (budget == 0) begin
        n_errors++;
        $display("FAIL timeout: actual %0d dones, required %0d", n_done, want);
        bus.req = 2'b00;
        break;
      end
      budget--;
      if (toggle) bus.step = ~bus.step;
      bus.sel0 = (selx == -1) || (selx >= 0 && m_x == selx);
      bus.sel1 = bus.sel0;
    end
  endtask

  task automatic wait_x(input int target);
    int budget;
    budget = 300;
    while (m_x != target && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_errors++;
      $display("FAIL wait_x: actual %0d, required %0d", m_x, target);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req = 2'b00; bus.bound0 = '0; bus.bound1 = '0;
    bus.sel0 = 1'b0; bus.sel1 = 1'b0; bus.step = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt",  32'(bus.gnt),  32'd0);
    chk("rst_x",    32'(bus.x),    32'd0);
    chk("rst_m",    32'(bus.m),    32'd0);
    chk("rst_n",    32'(bus.n),    32'd500);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hit",  32'(bus.hit),  32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_did",  32'(bus.done_id), 32'd0);
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Single scan, bound 5, selector only at x=3.
    clear_obs();
    bus.bound0 = 11'd5; bus.step = 1'b1; bus.req = 2'b01;
    tick();
    chk("s1_gnt_latency", 32'(bus.gnt), 32'd1);
    chk("s1_x_start",     32'(bus.x),   32'd0);
    run_until_done(1, 1'b0, 3);
    tick();
    chk("s1_x",     32'(bus.x),   32'd5);
    chk("s1_m",     32'(bus.m),   32'd3);
    chk("s1_hit",   32'(bus.hit), 32'd1);
    chk("s1_n",     32'(bus.n),   32'd5);
    chk("s1_gnt",   32'(bus.gnt), 32'd0);
    chk("s1_dones", 32'(n_done),  32'd1);
    chk("s1_did",   32'(did_seen[0]), 32'd0);

    // Both requesting continuously: grants alternate with one idle cycle between.
    pulse_reset();
    tick();
    clear_obs();
    bus.bound0 = 11'd2; bus.bound1 = 11'd3; bus.step = 1'b1; bus.req = 2'b11;
    run_until_done(3, 1'b0, -2);
    tick();
    chk("s2_g0",   32'(gnt_seen[0]), 32'd1);
    chk("s2_g1",   32'(gnt_seen[1]), 32'd2);
    chk("s2_g2",   32'(gnt_seen[2]), 32'd1);
    chk("s2_gap1", 32'(gaps[1]),     32'd1);
    chk("s2_gap2", 32'(gaps[2]),     32'd1);
    chk("s2_did0", 32'(did_seen[0]), 32'd0);
    chk("s2_did1", 32'(did_seen[1]), 32'd1);
    chk("s2_did2", 32'(did_seen[2]), 32'd0);

    // Zero bound: RUN then DONE immediately.
    clear_obs();
    bus.bound1 = 11'd0; bus.req = 2'b10; bus.sel1 = 1'b1;
    tick();
    chk("s3_gnt",  32'(bus.gnt),  32'd2);
    chk("s3_done0", 32'(bus.done), 32'd0);
    tick();
    chk("s3_done",  32'(bus.done),    32'd1);
    chk("s3_did",   32'(bus.done_id), 32'd1);
    chk("s3_x",     32'(bus.x),       32'd0);
    chk("s3_m",     32'(bus.m),       32'd0);
    chk("s3_hit",   32'(bus.hit),     32'd0);
    bus.req = 2'b00;
    tick();
    chk("s3_gnt_off", 32'(bus.gnt), 32'd0);
    chk("s3_dones",   32'(n_done),  32'd1);

    // Step toggling, selector always high.
    clear_obs();
    bus.bound0 = 11'd4; bus.step = 1'b1; bus.req = 2'b01;
    run_until_done(1, 1'b1, -1);
    tick();
    chk("s4_x",     32'(bus.x),   32'd4);
    chk("s4_m",     32'(bus.m),   32'd3);
    chk("s4_hit",   32'(bus.hit), 32'd1);
    chk("s4_dones", 32'(n_done),  32'd1);

    // Abort at x=10 with requester 1 waiting.
    clear_obs();
    bus.bound0 = 11'd100; bus.bound1 = 11'd3; bus.step = 1'b1;
    bus.sel0 = 1'b0; bus.sel1 = 1'b0; bus.req = 2'b01;
    wait_x(10);
    bus.req = 2'b10;
    tick();
    chk("s5_gnt_abort", 32'(bus.gnt),  32'd0);
    chk("s5_x_hold",    32'(bus.x),    32'd10);
    chk("s5_no_done",   32'(bus.done), 32'd0);
    tick();
    chk("s5_gnt_next",  32'(bus.gnt),  32'd2);
    chk("s5_n_next",    32'(bus.n),    32'd3);
    run_until_done(1, 1'b0, -2);
    tick();
    chk("s5_dones", 32'(n_done),      32'd1);
    chk("s5_did",   32'(did_seen[0]), 32'd1);
    bus.bound0 = 11'd1; bus.req = 2'b11;
    tick();
    chk("s5_rr_after", 32'(bus.gnt), 32'd1);
    run_until_done(2, 1'b0, -2);
    tick();

    // Asynchronous reset mid-scan.
    clear_obs();
    bus.bound0 = 11'd100; bus.step = 1'b1; bus.req = 2'b01;
    wait_x(7);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_x",    32'(bus.x),    32'd0);
    chk("s6_m",    32'(bus.m),    32'd0);
    chk("s6_n",    32'(bus.n),    32'd500);
    chk("s6_gnt",  32'(bus.gnt),  32'd0);
    chk("s6_busy", 32'(bus.busy), 32'd0);
    chk("s6_done", 32'(bus.done), 32'd0);
    bus.req = 2'b00;
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("s6_idle", 32'(bus.gnt), 32'd0);
    end
    bus.req = 2'b01;
    tick();
    chk("s6_regrant", 32'(bus.gnt), 32'd1);
    chk("s6_regrant_n", 32'(bus.n), 32'd100);
    bus.req = 2'b00;
    tick();
    tick();
    chk("s6_gnt_off", 32'(bus.gnt),  32'd0);
    chk("s6_dones",   32'(n_done),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual time %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
